// File: rtl/gon_axi_rd_arbiter.sv
// rtl/gon_axi_rd_arbiter.sv - two-requester AXI read-channel arbiter, one burst in flight
//
// Purpose: shares one AXI read master port between requesters S0 and S1.
//   Round-robin grant in IDLE, AR mux in ADDR, R routing in DATA. A beat
//   counter loaded from ARLEN flags RLAST/beat-count mismatches on ERR_LAST.
//
// Ports:
//   AXI_ACLK, AXI_ARESET_N        clock, asynchronous active-low reset
//   Sn_AR* / Sn_ARVALID/ARREADY   requester address channels (n = 0,1)
//   Sn_R*  / Sn_RVALID/RREADY     requester read-data channels
//   AXI_AR* / AXI_ARVALID/ARREADY master address channel
//   AXI_R*  / AXI_RVALID/RREADY   master read-data channel
//   ERR_LAST                      sticky beat-count / RLAST mismatch flag
//   ERR_TIMEOUT                   sticky DATA-phase timeout flag (option only)
//
// Option macro: GON_AXI_RD_ARB_TIMEOUT_EN adds ERR_TIMEOUT and a 256-cycle
//   no-handshake timeout in DATA that abandons the burst and returns to IDLE.

module gon_axi_rd_arbiter #(
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_AXI_LEN_WIDTH  = 4
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESET_N,

  input  logic [C_AXI_ID_WIDTH-1:0]   S0_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic [C_AXI_LEN_WIDTH-1:0]  S0_ARLEN,
  input  logic [2:0]                  S0_ARSIZE,
  input  logic [1:0]                  S0_ARBURST,
  input  logic                        S0_ARVALID,
  output logic                        S0_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   S0_RID,
  output logic [C_AXI_DATA_WIDTH-1:0] S0_RDATA,
  output logic [1:0]                  S0_RRESP,
  output logic                        S0_RLAST,
  output logic                        S0_RVALID,
  input  logic                        S0_RREADY,

  input  logic [C_AXI_ID_WIDTH-1:0]   S1_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic [C_AXI_LEN_WIDTH-1:0]  S1_ARLEN,
  input  logic [2:0]                  S1_ARSIZE,
  input  logic [1:0]                  S1_ARBURST,
  input  logic                        S1_ARVALID,
  output logic                        S1_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   S1_RID,
  output logic [C_AXI_DATA_WIDTH-1:0] S1_RDATA,
  output logic [1:0]                  S1_RRESP,
  output logic                        S1_RLAST,
  output logic                        S1_RVALID,
  input  logic                        S1_RREADY,

  output logic [C_AXI_ID_WIDTH-1:0]   AXI_ARID,
  output logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
  output logic [C_AXI_LEN_WIDTH-1:0]  AXI_ARLEN,
  output logic [2:0]                  AXI_ARSIZE,
  output logic [1:0]                  AXI_ARBURST,
  output logic                        AXI_ARVALID,
  input  logic                        AXI_ARREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]   AXI_RID,
  input  logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
  input  logic [1:0]                  AXI_RRESP,
  input  logic                        AXI_RLAST,
  input  logic                        AXI_RVALID,
  output logic                        AXI_RREADY,

  output logic                        ERR_LAST
`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
  ,
  output logic                        ERR_TIMEOUT
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [C_AXI_LEN_WIDTH:0] CNT_ONE = {{C_AXI_LEN_WIDTH{1'b0}}, 1'b1};

  state_t                   state_q;
  logic                     grant_q;   // 0 = S0, 1 = S1
  logic                     last_q;    // requester served most recently
  logic [C_AXI_LEN_WIDTH:0] cnt_q;     // beats still expected
  logic                     err_last_q;
  logic                     grant_d;
  logic                     ar_hs;
  logic                     r_hs;

`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
  logic [7:0]               idle_cnt_q;
  logic                     err_timeout_q;
  assign ERR_TIMEOUT = err_timeout_q;
`endif

  assign ERR_LAST = err_last_q;

  // Contention goes to whoever was not served last; reset value of last_q
  // (S1) makes S0 win the first contended grant.
  always_comb begin
    grant_d = 1'b0;
    if (S0_ARVALID && S1_ARVALID) begin
      grant_d = ~last_q;
    end else if (S1_ARVALID) begin
      grant_d = 1'b1;
    end
  end

  // Payload muxes are free-running; only the handshake signals are gated
  // by state so IDLE (and reset) leaves every valid/ready low.
  always_comb begin
    AXI_ARID    = grant_q ? S1_ARID    : S0_ARID;
    AXI_ARADDR  = grant_q ? S1_ARADDR  : S0_ARADDR;
    AXI_ARLEN   = grant_q ? S1_ARLEN   : S0_ARLEN;
    AXI_ARSIZE  = grant_q ? S1_ARSIZE  : S0_ARSIZE;
    AXI_ARBURST = grant_q ? S1_ARBURST : S0_ARBURST;
    AXI_ARVALID = 1'b0;
    S0_ARREADY  = 1'b0;
    S1_ARREADY  = 1'b0;
    AXI_RREADY  = 1'b0;
    S0_RVALID   = 1'b0;
    S1_RVALID   = 1'b0;
    if (state_q == ADDR) begin
      AXI_ARVALID = grant_q ? S1_ARVALID : S0_ARVALID;
      S0_ARREADY  = ~grant_q & AXI_ARREADY;
      S1_ARREADY  = grant_q & AXI_ARREADY;
    end
    if (state_q == DATA) begin
      AXI_RREADY = grant_q ? S1_RREADY : S0_RREADY;
      S0_RVALID  = ~grant_q & AXI_RVALID;
      S1_RVALID  = grant_q & AXI_RVALID;
    end
  end

  assign S0_RID   = AXI_RID;
  assign S0_RDATA = AXI_RDATA;
  assign S0_RRESP = AXI_RRESP;
  assign S0_RLAST = AXI_RLAST;
  assign S1_RID   = AXI_RID;
  assign S1_RDATA = AXI_RDATA;
  assign S1_RRESP = AXI_RRESP;
  assign S1_RLAST = AXI_RLAST;

  assign ar_hs = AXI_ARVALID & AXI_ARREADY;
  assign r_hs  = AXI_RVALID & AXI_RREADY;

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;
      cnt_q         <= '0;
      err_last_q    <= 1'b0;
`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
      idle_cnt_q    <= 8'd0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (S0_ARVALID || S1_ARVALID) begin
            grant_q <= grant_d;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            cnt_q   <= {1'b0, AXI_ARLEN} + CNT_ONE;
`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
            idle_cnt_q <= 8'd0;
`endif
            state_q <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            // Counter saturates at 0 so extra beats before RLAST stay flagged.
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_ONE;
            end
`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
            idle_cnt_q <= 8'd0;
`endif
            if (AXI_RLAST) begin
              if (cnt_q != CNT_ONE) begin
                err_last_q <= 1'b1;
              end
              last_q  <= grant_q;
              state_q <= IDLE;
            end else if (cnt_q <= CNT_ONE) begin
              // Count exhausted but slave has not said RLAST; keep waiting.
              err_last_q <= 1'b1;
            end
          end
`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
          else if (idle_cnt_q == 8'hFF) begin
            err_timeout_q <= 1'b1;
            last_q        <= grant_q;
            state_q       <= IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gon_axi_rd_arbiter.sv
// tb/tb_gon_axi_rd_arbiter.sv - scoreboard bench for gon_axi_rd_arbiter
module tb_gon_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:0]  s0_arid, s1_arid, s0_rid, s1_rid, axi_arid, axi_rid;
  logic [31:0] s0_araddr, s1_araddr, axi_araddr;
  logic [3:0]  s0_arlen, s1_arlen, axi_arlen;
  logic [2:0]  s0_arsize, s1_arsize, axi_arsize;
  logic [1:0]  s0_arburst, s1_arburst, axi_arburst;
  logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [63:0] s0_rdata, s1_rdata, axi_rdata;
  logic [1:0]  s0_rresp, s1_rresp, axi_rresp;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic        axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic        err_last;
`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
  logic        err_timeout;
`endif

  int tests = 0;
  int fails = 0;
  int          exp_grant_q[$];
  logic [63:0] exp_data_q[$];

  gon_axi_rd_arbiter dut (
    .AXI_ACLK(clk), .AXI_ARESET_N(rst_n),
    .S0_ARID(s0_arid), .S0_ARADDR(s0_araddr), .S0_ARLEN(s0_arlen), .S0_ARSIZE(s0_arsize),
    .S0_ARBURST(s0_arburst), .S0_ARVALID(s0_arvalid), .S0_ARREADY(s0_arready),
    .S0_RID(s0_rid), .S0_RDATA(s0_rdata), .S0_RRESP(s0_rresp), .S0_RLAST(s0_rlast),
    .S0_RVALID(s0_rvalid), .S0_RREADY(s0_rready),
    .S1_ARID(s1_arid), .S1_ARADDR(s1_araddr), .S1_ARLEN(s1_arlen), .S1_ARSIZE(s1_arsize),
    .S1_ARBURST(s1_arburst), .S1_ARVALID(s1_arvalid), .S1_ARREADY(s1_arready),
    .S1_RID(s1_rid), .S1_RDATA(s1_rdata), .S1_RRESP(s1_rresp), .S1_RLAST(s1_rlast),
    .S1_RVALID(s1_rvalid), .S1_RREADY(s1_rready),
    .AXI_ARID(axi_arid), .AXI_ARADDR(axi_araddr), .AXI_ARLEN(axi_arlen), .AXI_ARSIZE(axi_arsize),
    .AXI_ARBURST(axi_arburst), .AXI_ARVALID(axi_arvalid), .AXI_ARREADY(axi_arready),
    .AXI_RID(axi_rid), .AXI_RDATA(axi_rdata), .AXI_RRESP(axi_rresp), .AXI_RLAST(axi_rlast),
    .AXI_RVALID(axi_rvalid), .AXI_RREADY(axi_rready),
    .ERR_LAST(err_last)
`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
    , .ERR_TIMEOUT(err_timeout)
`endif
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    exp_grant_q.delete(); exp_data_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic request(input int req, input logic [3:0] len, input logic [31:0] addr);
    if (req == 0) begin
      s0_arvalid = 1'b1; s0_arlen = len; s0_araddr = addr; s0_arid = 1'b0;
    end else begin
      s1_arvalid = 1'b1; s1_arlen = len; s1_araddr = addr; s1_arid = 1'b1;
    end
    exp_grant_q.push_back(req);
  endtask

  // Slave side of the AR handshake; checks the grant against the scoreboard.
  task automatic do_ar(output int waited, output int exp);
    waited = 0;
    exp = -1;
    while (axi_arvalid !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    tests++;
    if (axi_arvalid !== 1'b1) begin
      fails++;
      $display("FAIL ar_wait: AXI_ARVALID=%b after %0d cycles, required 1", axi_arvalid, waited);
      return;
    end
    if (exp_grant_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL grant_unexpected: AR issued, required no pending request");
      return;
    end
    exp = exp_grant_q.pop_front();
    axi_arready = 1'b1;
    #1;
    tests++;
    if (s0_arready !== (exp == 0) || s1_arready !== (exp == 1)) begin
      fails++;
      $display("FAIL grant: S0_ARREADY=%b S1_ARREADY=%b, required grant to S%0d", s0_arready, s1_arready, exp);
    end
    tests++;
    if (axi_araddr !== ((exp == 1) ? s1_araddr : s0_araddr) ||
        axi_arlen !== ((exp == 1) ? s1_arlen : s0_arlen)) begin
      fails++;
      $display("FAIL ar_mux: ARADDR=%h ARLEN=%0d, required payload of S%0d", axi_araddr, axi_arlen, exp);
    end
    @(posedge clk); #1;
    axi_arready = 1'b0;
    if (exp == 0) s0_arvalid = 1'b0;
    else          s1_arvalid = 1'b0;
  endtask

  task automatic send_beats(input int req, input int nbeats, input int last_at);
    logic [63:0] want;
    logic [63:0] got;
    for (int b = 1; b <= nbeats; b++) begin
      axi_rvalid = 1'b1;
      axi_rdata  = {$urandom, $urandom};
      axi_rresp  = 2'(b);
      axi_rlast  = (b == last_at);
      exp_data_q.push_back(axi_rdata);
      #1;
      tests++;
      if (((req == 1) ? s1_rvalid : s0_rvalid) !== 1'b1 ||
          ((req == 1) ? s0_rvalid : s1_rvalid) !== 1'b0 || axi_rready !== 1'b1) begin
        fails++;
        $display("FAIL r_route beat %0d: S0_RVALID=%b S1_RVALID=%b RREADY=%b, required S%0d only",
                 b, s0_rvalid, s1_rvalid, axi_rready, req);
      end
      want = exp_data_q.pop_front();
      got  = (req == 1) ? s1_rdata : s0_rdata;
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL r_data beat %0d: got %h, required %h", b, got, want);
      end
      @(posedge clk); #1;
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    tests++;
    if (axi_arvalid !== 1'b0 || axi_rready !== 1'b0 || s0_arready !== 1'b0 || s1_arready !== 1'b0 ||
        s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL %s: ARVALID=%b RREADY=%b AR0=%b AR1=%b RV0=%b RV1=%b, required all 0",
               tag, axi_arvalid, axi_rready, s0_arready, s1_arready, s0_rvalid, s1_rvalid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_idle("reset_outputs");
    tests++;
    if (err_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_err_last: got %b, required 0", err_last);
    end
  endtask

  task automatic test_single_burst();
    int w, g;
    request(0, 4'd3, 32'h1000_0000);
    do_ar(w, g);
    tests++;
    if (w !== 1) begin
      fails++;
      $display("FAIL ar_latency: ARVALID after %0d cycles, required 1", w);
    end
    send_beats(0, 4, 4);
    tests++;
    if (err_last !== 1'b0) begin
      fails++;
      $display("FAIL single_err_last: got %b, required 0", err_last);
    end
    check_idle("single_idle_after_last");
  endtask

  task automatic test_same_cycle();
    int w, g;
    apply_reset();
    request(0, 4'd1, 32'h0000_0100);
    request(1, 4'd2, 32'h0000_0200);
    do_ar(w, g);
    send_beats(0, 2, 2);
    do_ar(w, g);
    tests++;
    if (w !== 1) begin
      fails++;
      $display("FAIL back_to_back_gap: S1 ARVALID %0d cycles after RLAST handshake, required 1", w);
    end
    send_beats(1, 3, 3);
  endtask

  task automatic test_round_robin();
    int w, g;
    request(0, 4'd0, 32'h0000_A000);
    request(1, 4'd0, 32'h0000_B000);
    do_ar(w, g);
    send_beats(0, 1, 1);
    request(0, 4'd1, 32'h0000_A100);
    do_ar(w, g);
    send_beats(1, 1, 1);
    do_ar(w, g);
    send_beats(0, 2, 2);
    tests++;
    if (exp_grant_q.size() != 0 || err_last !== 1'b0) begin
      fails++;
      $display("FAIL rr_done: pending=%0d err_last=%b, required 0 and 0", exp_grant_q.size(), err_last);
    end
  endtask

  task automatic test_err_early_last();
    int w, g;
    apply_reset();
    request(1, 4'd1, 32'h0000_C000);
    do_ar(w, g);
    send_beats(1, 1, 1);
    tests++;
    if (err_last !== 1'b1) begin
      fails++;
      $display("FAIL err_early_last: got %b, required 1", err_last);
    end
    request(0, 4'd0, 32'h0000_C100);
    do_ar(w, g);
    send_beats(0, 1, 1);
    tests++;
    if (err_last !== 1'b1) begin
      fails++;
      $display("FAIL err_last_sticky: got %b, required 1", err_last);
    end
  endtask

  task automatic test_reset_mid_burst();
    int w, g;
    request(0, 4'd3, 32'h0000_D000);
    do_ar(w, g);
    send_beats(0, 1, 0);
    axi_rvalid = 1'b1;
    axi_rdata  = 64'h0;
    #1 rst_n = 1'b0;
    #1;
    check_idle("reset_mid_burst");
    tests++;
    if (err_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_err_last: got %b, required 0", err_last);
    end
    axi_rvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    request(1, 4'd0, 32'h0000_D100);
    request(0, 4'd0, 32'h0000_D200);
    exp_grant_q.delete();
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    do_ar(w, g);
    send_beats(0, 1, 1);
    do_ar(w, g);
    send_beats(1, 1, 1);
  endtask

  task automatic test_count_exhausted();
    int w, g;
    apply_reset();
    request(0, 4'd0, 32'h0000_E000);
    do_ar(w, g);
    send_beats(0, 2, 2);
    tests++;
    if (err_last !== 1'b1) begin
      fails++;
      $display("FAIL err_no_last: got %b, required 1", err_last);
    end
    check_idle("idle_after_late_last");
  endtask

`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int w, g;
    apply_reset();
    request(0, 4'd0, 32'h0000_F000);
    do_ar(w, g);
    repeat (255) begin
      @(posedge clk); #1;
    end
    tests++;
    if (err_timeout !== 1'b0 || axi_rready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early: ERR_TIMEOUT=%b RREADY=%b, required 0 and 1", err_timeout, axi_rready);
    end
    @(posedge clk); #1;
    tests++;
    if (err_timeout !== 1'b1 || axi_rready !== 1'b0) begin
      fails++;
      $display("FAIL timeout_fire: ERR_TIMEOUT=%b RREADY=%b, required 1 and 0", err_timeout, axi_rready);
    end
  endtask
`endif

  initial begin
    s0_arid = '0; s1_arid = '0; s0_araddr = '0; s1_araddr = '0;
    s0_arlen = '0; s1_arlen = '0; s0_arsize = 3'd3; s1_arsize = 3'd3;
    s0_arburst = 2'd1; s1_arburst = 2'd1; s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    s0_rready = 1'b1; s1_rready = 1'b1;
    axi_arready = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0;
    axi_rlast = 1'b0; axi_rvalid = 1'b0;

    test_reset();
    test_single_burst();
    test_same_cycle();
    test_round_robin();
    test_err_early_last();
    test_reset_mid_burst();
    test_count_exhausted();
`ifdef GON_AXI_RD_ARB_TIMEOUT_EN
    test_timeout();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
